// File: rtl/chacha_keystream_arbiter.sv
// chacha_keystream_arbiter
// Shares one ChaCha keystream core between two requesters (0 = tx encryptor,
// 1 = rx decryptor). Round-robin accept, start pulse, bounded wait for done,
// keystream returned to the granted requester over valid/ready.
// Optional build macro CHACHA_ARB_STATS_EN: per-requester saturating grant
// counters on grant_cnt0/grant_cnt1 (tied to zero when undefined).
module chacha_keystream_arbiter #(
  parameter int unsigned CHACHA_KEY_WIDTH         = 256,
  parameter int unsigned CHACHA_NONCE_WIDTH       = 96,
  parameter int unsigned CHACHA_BLOCK_COUNT_WIDTH = 32,
  parameter int unsigned CHACHA_OUT_WIDTH         = 512,
  parameter int unsigned CORE_TIMEOUT             = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [CHACHA_KEY_WIDTH-1:0]         key,
  input  logic [1:0]                          req_valid,
  output logic [1:0]                          req_ready,
  input  logic [CHACHA_NONCE_WIDTH-1:0]       req0_nonce,
  input  logic [CHACHA_BLOCK_COUNT_WIDTH-1:0] req0_block_count,
  input  logic [CHACHA_NONCE_WIDTH-1:0]       req1_nonce,
  input  logic [CHACHA_BLOCK_COUNT_WIDTH-1:0] req1_block_count,
  output logic [1:0]                          rsp_valid,
  input  logic [1:0]                          rsp_ready,
  output logic [CHACHA_OUT_WIDTH-1:0]         rsp_keystream,
  output logic                                core_start,
  output logic [CHACHA_KEY_WIDTH-1:0]         core_key,
  output logic [CHACHA_NONCE_WIDTH-1:0]       core_nonce,
  output logic [CHACHA_BLOCK_COUNT_WIDTH-1:0] core_block_count,
  input  logic                                core_done,
  input  logic [CHACHA_OUT_WIDTH-1:0]         core_keystream,
  output logic                                timeout_err,
  output logic [15:0]                         grant_cnt0,
  output logic [15:0]                         grant_cnt1
);

  localparam int unsigned     CNT_W    = (CORE_TIMEOUT > 2) ? $clog2(CORE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CORE_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic             rr_ptr;
  logic             gnt_q;
  logic             gnt_idx;
  logic             accept;
  logic             done_hit;
  logic             timeout_hit;
  logic             rsp_hs;
  logic [CNT_W-1:0] wait_cnt;

  // Grant selection: a lone requester wins outright, a tie goes to rr_ptr
  always_comb begin
    gnt_idx = 1'b0;
    case (req_valid)
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = rr_ptr;
      default: gnt_idx = 1'b0;
    endcase
  end

  // Next-state decode plus combinational accept handshake
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    rsp_hs      = 1'b0;
    req_ready   = '0;
    case (state)
      IDLE: begin
        // reset gating keeps req_ready low while reset is held
        if ((req_valid != 2'b00) && !reset) begin
          accept    = 1'b1;
          req_ready = gnt_idx ? 2'b10 : 2'b01;
          state_nxt = START;
        end
      end
      START: state_nxt = WAIT;
      WAIT: begin
        // done takes precedence over a coincident timeout
        if (core_done) begin
          done_hit  = 1'b1;
          state_nxt = RESP;
        end else if (wait_cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      RESP: begin
        if (rsp_ready[gnt_q]) begin
          rsp_hs    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Control registers: start/error pulses, response valid, fairness pointer, wait counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_start  <= 1'b0;
      timeout_err <= 1'b0;
      rsp_valid   <= '0;
      rr_ptr      <= 1'b0;
      gnt_q       <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      core_start  <= accept;
      timeout_err <= timeout_hit;
      if (accept) gnt_q <= gnt_idx;
      if (done_hit)    rsp_valid <= gnt_q ? 2'b10 : 2'b01;
      else if (rsp_hs) rsp_valid <= '0;
      if (timeout_hit || rsp_hs) rr_ptr <= ~gnt_q;
      if (state == START)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Operand latch at accept and keystream capture at done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_key         <= '0;
      core_nonce       <= '0;
      core_block_count <= '0;
      rsp_keystream    <= '0;
    end else begin
      if (accept) begin
        core_key         <= key;
        core_nonce       <= gnt_idx ? req1_nonce : req0_nonce;
        core_block_count <= gnt_idx ? req1_block_count : req0_block_count;
      end
      if (done_hit) rsp_keystream <= core_keystream;
    end
  end

`ifdef CHACHA_ARB_STATS_EN
  // Saturating per-requester accept counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (accept) begin
      if (!gnt_idx && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (gnt_idx && (grant_cnt1 != '1))  grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_chacha_keystream_arbiter.sv
// Self-checking bench for chacha_keystream_arbiter: scenario tasks with
// randomized operands/latencies against a transaction-level reference model.
module tb_chacha_keystream_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] key;
  logic [1:0]   req_valid, req_ready;
  logic [95:0]  req0_nonce, req1_nonce;
  logic [31:0]  req0_block_count, req1_block_count;
  logic [1:0]   rsp_valid, rsp_ready;
  logic [511:0] rsp_keystream;
  logic         core_start;
  logic [255:0] core_key;
  logic [95:0]  core_nonce;
  logic [31:0]  core_block_count;
  logic         core_done;
  logic [511:0] core_keystream;
  logic         timeout_err;
  logic [15:0]  grant_cnt0, grant_cnt1;

  chacha_keystream_arbiter #(
    .CHACHA_KEY_WIDTH(256), .CHACHA_NONCE_WIDTH(96), .CHACHA_BLOCK_COUNT_WIDTH(32),
    .CHACHA_OUT_WIDTH(512), .CORE_TIMEOUT(64)
  ) dut (
    .clk(clk), .reset(reset), .key(key), .req_valid(req_valid), .req_ready(req_ready),
    .req0_nonce(req0_nonce), .req0_block_count(req0_block_count),
    .req1_nonce(req1_nonce), .req1_block_count(req1_block_count),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_keystream(rsp_keystream),
    .core_start(core_start), .core_key(core_key), .core_nonce(core_nonce),
    .core_block_count(core_block_count), .core_done(core_done),
    .core_keystream(core_keystream), .timeout_err(timeout_err),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic         ref_rr;
  int           exp_cnt0, exp_cnt1;
  logic         exp_g;
  logic [255:0] exp_key;
  logic [95:0]  exp_nonce;
  logic [31:0]  exp_bc;
  logic [511:0] exp_ks;

  // observations of the latest transaction
  logic [1:0]   obs_ready, obs_rsp_valid, obs_after;
  logic         obs_start, obs_to_after;
  logic [255:0] obs_key;
  logic [95:0]  obs_nonce;
  logic [31:0]  obs_bc;
  logic [511:0] obs_ks;
  int           obs_rsp_cyc, obs_to, obs_unstable, obs_busy_ready, obs_extra_start, obs_early_rsp;

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [1:0] oh(input logic g);
    return g ? 2'b10 : 2'b01;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; rsp_ready = '0; core_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    ref_rr = 1'b0; exp_cnt0 = 0; exp_cnt1 = 0;
  endtask

  // Drive one full transaction. lat = cycles from core_start to core_done
  // (-1 = never). rdelay = extra cycles of rsp_ready backpressure.
  task automatic do_txn(input logic [1:0] v, input int lat, input int rdelay, input bit hold_valid);
    logic [511:0] t;
    bit got_done;
    int s0;
    got_done = 0;
    obs_start = 0; obs_to = -1; obs_to_after = 0; obs_rsp_cyc = -1; obs_rsp_valid = '0;
    obs_ks = '0; obs_unstable = 0; obs_busy_ready = 0; obs_extra_start = 0; obs_early_rsp = 0;
    obs_after = '0;
    t = rand512(); key = t[255:0];
    t = rand512();
    req0_nonce = t[95:0];    req0_block_count = t[127:96];
    req1_nonce = t[223:128]; req1_block_count = t[255:224];
    exp_g     = (v == 2'b01) ? 1'b0 : (v == 2'b10) ? 1'b1 : ref_rr;
    exp_key   = key;
    exp_nonce = exp_g ? req1_nonce : req0_nonce;
    exp_bc    = exp_g ? req1_block_count : req0_block_count;
    // accept cycle T
    req_valid = v;
    #1;
    obs_ready = req_ready; s0 = cyc;
    tick();
    // START cycle: operands must be the ones captured at accept
    if (!hold_valid) req_valid = 2'($urandom);
    t = rand512(); key = t[255:0]; req0_nonce = t[351:256]; req1_nonce = t[447:352];
    #1;
    obs_start = core_start; obs_key = core_key; obs_nonce = core_nonce; obs_bc = core_block_count;
    if (req_ready != 2'b00) obs_busy_ready++;
    tick();
    // WAIT: iteration k is the k-th cycle after the start cycle
    for (int k = 1; k <= 70; k++) begin
      if (k == lat) begin
        t = rand512(); core_keystream = t; exp_ks = t; core_done = 1'b1;
      end
      if (!hold_valid) req_valid = (k <= 64) ? 2'($urandom) : 2'b00;
      #1;
      if (core_start) obs_extra_start++;
      if (k <= 64 && req_ready != 2'b00) obs_busy_ready++;
      if (rsp_valid != 2'b00) obs_early_rsp++;
      if (timeout_err && obs_to < 0) obs_to = k;
      tick();
      core_done = 1'b0;
      if (k == lat) begin got_done = 1; break; end
      if (obs_to >= 0) begin
        req_valid = '0;
        #1;
        obs_to_after = timeout_err;
        break;
      end
    end
    if (got_done) begin
      for (int w = 0; w < 4; w++) begin
        if (!hold_valid) req_valid = 2'($urandom);
        rsp_ready = '0;
        #1;
        if (timeout_err && obs_to < 0) obs_to = 100 + w;
        if (req_ready != 2'b00) obs_busy_ready++;
        if (rsp_valid != 2'b00) begin
          obs_rsp_cyc = cyc - s0; obs_rsp_valid = rsp_valid; obs_ks = rsp_keystream;
          break;
        end
        tick();
      end
      if (obs_rsp_cyc >= 0) begin
        // backpressure: non-granted ready bit and spurious done must be ignored
        for (int d = 0; d < rdelay; d++) begin
          tick();
          if (!hold_valid) req_valid = 2'($urandom);
          rsp_ready = ~obs_rsp_valid & 2'($urandom);
          core_keystream = rand512(); core_done = 1'($urandom);
          #1;
          if (rsp_valid !== obs_rsp_valid || rsp_keystream !== obs_ks) obs_unstable++;
          if (req_ready != 2'b00) obs_busy_ready++;
          if (core_start) obs_extra_start++;
        end
        tick();
        core_done = 1'b0;
        rsp_ready = obs_rsp_valid | (~obs_rsp_valid & 2'($urandom));
        #1;
        if (rsp_valid !== obs_rsp_valid || rsp_keystream !== obs_ks) obs_unstable++;
        if (req_ready != 2'b00) obs_busy_ready++;
        tick();
        rsp_ready = '0;
        req_valid = hold_valid ? v : 2'b00;
        #1;
        obs_after = rsp_valid;
      end
    end
    core_done = 1'b0;
    rsp_ready = '0;
    if (!hold_valid) req_valid = '0;
    ref_rr = ~exp_g;
    if (exp_g) exp_cnt1++; else exp_cnt0++;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11; core_done = 1'b1;
    core_keystream = rand512(); key = '1;
    req0_nonce = '1; req1_nonce = '1; req0_block_count = '1; req1_block_count = '1;
    tick(); tick();
    #1;
    total++; if ({req_ready, rsp_valid, core_start, timeout_err} !== 6'b0) begin bad++; $display("FAIL reset_ctrl got=%b want=0", {req_ready, rsp_valid, core_start, timeout_err}); end
    total++; if (rsp_keystream !== '0) begin bad++; $display("FAIL reset_ks got=%h want=0", rsp_keystream); end
    total++; if ({core_key, core_nonce, core_block_count} !== '0) begin bad++; $display("FAIL reset_operands got nonzero want=0"); end
    total++; if ({grant_cnt0, grant_cnt1} !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%h want=0", {grant_cnt0, grant_cnt1}); end
    core_done = 1'b0;
    do_reset();
  endtask

  task automatic test_single_requester();
    int lat;
    do_txn(2'b01, 10, 0, 0);
    total++; if (obs_ready !== 2'b01) begin bad++; $display("FAIL single_ready got=%b want=01", obs_ready); end
    total++; if (obs_start !== 1'b1) begin bad++; $display("FAIL single_start got=%b want=1", obs_start); end
    total++; if (obs_key !== exp_key || obs_nonce !== exp_nonce || obs_bc !== exp_bc) begin bad++; $display("FAIL single_operands got=%h/%h want=%h/%h", obs_nonce, obs_bc, exp_nonce, exp_bc); end
    total++; if (obs_rsp_cyc !== 12) begin bad++; $display("FAIL single_latency got=%0d want=12", obs_rsp_cyc); end
    total++; if (obs_rsp_valid !== 2'b01 || obs_ks !== exp_ks) begin bad++; $display("FAIL single_rsp got=%b/%h want=01/%h", obs_rsp_valid, obs_ks, exp_ks); end
    total++; if (obs_after !== 2'b00 || obs_extra_start !== 0) begin bad++; $display("FAIL single_after got=%b/%0d want=00/0", obs_after, obs_extra_start); end
    lat = $urandom_range(1, 20);
    do_txn(2'b10, lat, 0, 0);
    total++; if (obs_ready !== 2'b10) begin bad++; $display("FAIL single1_ready got=%b want=10", obs_ready); end
    total++; if (obs_rsp_cyc !== lat + 2 || obs_ks !== exp_ks) begin bad++; $display("FAIL single1_rsp got=%0d/%h want=%0d/%h", obs_rsp_cyc, obs_ks, lat + 2, exp_ks); end
    total++; if (obs_nonce !== exp_nonce || obs_bc !== exp_bc) begin bad++; $display("FAIL single1_operands got=%h want=%h", obs_nonce, exp_nonce); end
  endtask

  task automatic test_alternate();
    logic [1:0] order [4];
    order = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_txn(2'b11, $urandom_range(1, 12), $urandom_range(0, 2), 1);
      total++; if (obs_ready !== order[i] || obs_rsp_valid !== order[i]) begin bad++; $display("FAIL alt_grant%0d got=%b/%b want=%b", i, obs_ready, obs_rsp_valid, order[i]); end
      total++; if (obs_nonce !== exp_nonce || obs_ks !== exp_ks) begin bad++; $display("FAIL alt_data%0d got=%h want=%h", i, obs_nonce, exp_nonce); end
    end
    req_valid = '0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] v;
    v = 2'($urandom_range(1, 3));
    do_txn(v, 5, 20, 0);
    total++; if (obs_unstable !== 0) begin bad++; $display("FAIL bp_stable got=%0d want=0", obs_unstable); end
    total++; if (obs_busy_ready !== 0) begin bad++; $display("FAIL bp_busy_ready got=%0d want=0", obs_busy_ready); end
    total++; if (obs_extra_start !== 0) begin bad++; $display("FAIL bp_extra_start got=%0d want=0", obs_extra_start); end
    total++; if (obs_rsp_valid !== oh(exp_g) || obs_ks !== exp_ks || obs_after !== 2'b00) begin bad++; $display("FAIL bp_rsp got=%b/%b want=%b/00", obs_rsp_valid, obs_after, oh(exp_g)); end
  endtask

  task automatic test_timeout();
    do_txn(2'b01, -1, 0, 0);
    total++; if (obs_to !== 65) begin bad++; $display("FAIL to_cycle got=%0d want=65", obs_to); end
    total++; if (obs_to_after !== 1'b0) begin bad++; $display("FAIL to_width got=%b want=0", obs_to_after); end
    total++; if (obs_early_rsp !== 0 || obs_rsp_cyc !== -1) begin bad++; $display("FAIL to_norsp got=%0d/%0d want=0/-1", obs_early_rsp, obs_rsp_cyc); end
    do_txn(2'b11, 3, 0, 0);
    total++; if (obs_ready !== 2'b10) begin bad++; $display("FAIL to_next_grant got=%b want=10", obs_ready); end
  endtask

  task automatic test_done_at_timeout();
    logic [511:0] held;
    do_txn(2'b10, 64, 1, 0);
    total++; if (obs_to !== -1) begin bad++; $display("FAIL dat_no_err got=%0d want=-1", obs_to); end
    total++; if (obs_rsp_cyc !== 66 || obs_rsp_valid !== 2'b10 || obs_ks !== exp_ks) begin bad++; $display("FAIL dat_rsp got=%0d/%b want=66/10", obs_rsp_cyc, obs_rsp_valid); end
    held = obs_ks;
    core_keystream = rand512(); core_done = 1'b1;
    tick();
    core_done = 1'b0;
    #1;
    total++; if (rsp_valid !== 2'b00 || rsp_keystream !== held || core_start !== 1'b0 || timeout_err !== 1'b0) begin bad++; $display("FAIL idle_done got=%b/%b/%b want=00/0/0", rsp_valid, core_start, timeout_err); end
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b10;
    #1;
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    reset = 1'b1; req_valid = 2'b11;
    #1;
    total++; if ({req_ready, rsp_valid, core_start, timeout_err} !== 6'b0 || rsp_keystream !== '0 || core_nonce !== '0) begin bad++; $display("FAIL rmid_outputs got=%b want=0", {req_ready, rsp_valid, core_start, timeout_err}); end
    total++; if ({grant_cnt0, grant_cnt1} !== 32'h0) begin bad++; $display("FAIL rmid_cnt got=%h want=0", {grant_cnt0, grant_cnt1}); end
    tick();
    reset = 1'b0; req_valid = '0;
    ref_rr = 1'b0; exp_cnt0 = 0; exp_cnt1 = 0;
    do_txn(2'b11, 4, 0, 0);
    total++; if (obs_ready !== 2'b01) begin bad++; $display("FAIL rmid_prio got=%b want=01", obs_ready); end
  endtask

  task automatic test_random();
    logic [1:0] v;
    int lat;
    for (int i = 0; i < 25; i++) begin
      v   = 2'($urandom_range(1, 3));
      lat = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(1, 64);
      do_txn(v, lat, $urandom_range(0, 3), 0);
      total++; if (obs_ready !== oh(exp_g)) begin bad++; $display("FAIL rnd_grant%0d got=%b want=%b", i, obs_ready, oh(exp_g)); end
      total++; if (obs_start !== 1'b1 || obs_key !== exp_key || obs_nonce !== exp_nonce || obs_bc !== exp_bc) begin bad++; $display("FAIL rnd_operands%0d got=%h want=%h", i, obs_nonce, exp_nonce); end
      if (lat > 0) begin
        total++; if (obs_rsp_cyc !== lat + 2 || obs_rsp_valid !== oh(exp_g) || obs_ks !== exp_ks || obs_to !== -1) begin bad++; $display("FAIL rnd_rsp%0d got=%0d/%b want=%0d/%b", i, obs_rsp_cyc, obs_rsp_valid, lat + 2, oh(exp_g)); end
      end else begin
        total++; if (obs_to !== 65 || obs_early_rsp !== 0) begin bad++; $display("FAIL rnd_timeout%0d got=%0d want=65", i, obs_to); end
      end
      total++; if (obs_busy_ready !== 0 || obs_unstable !== 0 || obs_extra_start !== 0) begin bad++; $display("FAIL rnd_protocol%0d got=%0d/%0d/%0d want=0/0/0", i, obs_busy_ready, obs_unstable, obs_extra_start); end
    end
`ifdef CHACHA_ARB_STATS_EN
    total++; if (grant_cnt0 !== 16'(exp_cnt0) || grant_cnt1 !== 16'(exp_cnt1)) begin bad++; $display("FAIL rnd_stats got=%0d/%0d want=%0d/%0d", grant_cnt0, grant_cnt1, exp_cnt0, exp_cnt1); end
`else
    total++; if (grant_cnt0 !== 16'h0 || grant_cnt1 !== 16'h0) begin bad++; $display("FAIL rnd_stats got=%0d/%0d want=0/0", grant_cnt0, grant_cnt1); end
`endif
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; rsp_ready = '0; core_done = 1'b0;
    key = '0; req0_nonce = '0; req1_nonce = '0; req0_block_count = '0; req1_block_count = '0;
    core_keystream = '0;
    ref_rr = 1'b0; exp_cnt0 = 0; exp_cnt1 = 0;
    test_reset();
    test_single_requester();
    test_alternate();
    test_back_to_back();
    test_timeout();
    test_done_at_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
